// File: rtl/b2s_receiver.sv
// b2s single-wire link receiver: decodes start pattern plus WIDTH pulse-width coded bits (LSB first).
// Optional macro B2S_RX_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchroniser.
module b2s_receiver #(
  parameter int WIDTH      = 32,
  parameter int CNT_WIDTH  = 14,
  parameter int IDLE_MIN   = 16,
  parameter int START_MIN  = 12,
  parameter int START_MAX  = 28,
  parameter int BIT_THRESH = 77,
  parameter int LOW_MAX    = 400,
  parameter int HIGH_MAX   = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b2s_din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err,
  output logic [5:0]       bit_cnt
);

  // state      | meaning
  // IDLE       | line idle, counting continuous high before a start low
  // START_LOW  | measuring start-low width
  // START_HIGH | start high, waiting for first bit low
  // BIT_LOW    | measuring a data-bit low pulse
  // BIT_HIGH   | gap between data bits
  // DONE       | word complete, dout_valid pulse
  // ERR        | frame aborted, frame_err pulse
  typedef enum logic [2:0] {
    IDLE, START_LOW, START_HIGH, BIT_LOW, BIT_HIGH, DONE, ERR
  } state_t;

  localparam int CW1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH:0] IDLE_MIN_W   = CW1'(IDLE_MIN);
  localparam logic [CNT_WIDTH:0] START_MIN_W  = CW1'(START_MIN);
  localparam logic [CNT_WIDTH:0] START_MAX_W  = CW1'(START_MAX);
  localparam logic [CNT_WIDTH:0] BIT_THRESH_W = CW1'(BIT_THRESH);
  localparam logic [CNT_WIDTH:0] LOW_MAX_W    = CW1'(LOW_MAX);
  localparam logic [CNT_WIDTH:0] HIGH_MAX_W   = CW1'(HIGH_MAX);
  localparam logic [5:0]         WIDTH_B      = 6'(WIDTH);

  state_t state, state_next;

  logic sync1, sync2, line_s, line_d;
  logic rise, fall;

`ifdef B2S_RX_GLITCH_FILTER_EN
  logic hist1, hist2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      hist1  <= 1'b1;
      hist2  <= 1'b1;
      line_s <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= b2s_din;
      sync2  <= sync1;
      hist1  <= sync2;
      hist2  <= hist1;
      // line_s follows only after three equal synchronised samples
      if ((sync2 == hist1) && (hist1 == hist2))
        line_s <= sync2;
      line_d <= line_s;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_s <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= b2s_din;
      sync2  <= sync1;
      line_s <= sync2;
      line_d <= line_s;
    end
  end
`endif

  assign rise = line_s & ~line_d;
  assign fall = ~line_s & line_d;

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH:0]   width;

  // cnt lags by one cycle after an edge, so the level duration so far is cnt + 1
  assign width = {1'b0, cnt} + CW1'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (rise || fall || (state == DONE))
      cnt <= '0;
    else if (cnt != '1)
      cnt <= cnt + CNT_WIDTH'(1);
  end

  logic [WIDTH-1:0] dout_shift, shift_next;
  logic [5:0]       bit_cnt_next;

  always_comb begin
    state_next   = state;
    shift_next   = dout_shift;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE:
        if (fall && (width >= IDLE_MIN_W))
          state_next = START_LOW;
      START_LOW:
        if (rise)
          state_next = ((width >= START_MIN_W) && (width <= START_MAX_W)) ? START_HIGH : ERR;
        else if (width > LOW_MAX_W)
          state_next = ERR;
      START_HIGH, BIT_HIGH:
        if (fall)
          state_next = BIT_LOW;
        else if (width > HIGH_MAX_W)
          state_next = ERR;
      BIT_LOW:
        if (rise) begin
          // LSB arrives first, so shifting right leaves bit 0 at the bottom after WIDTH bits
          shift_next   = {(width < BIT_THRESH_W), dout_shift[WIDTH-1:1]};
          bit_cnt_next = bit_cnt + 6'd1;
          state_next   = (bit_cnt_next == WIDTH_B) ? DONE : BIT_HIGH;
        end else if (width > LOW_MAX_W) begin
          state_next = ERR;
        end
      DONE, ERR: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dout_shift <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      dout_shift <= shift_next;
      bit_cnt    <= bit_cnt_next;
      dout_valid <= (state_next == DONE);
      frame_err  <= (state_next == ERR);
      if (state_next == DONE)
        dout <= shift_next;
    end
  end

  assign busy = (state == START_LOW) || (state == START_HIGH) ||
                (state == BIT_LOW)   || (state == BIT_HIGH);

endmodule

// File: tb/tb_b2s_receiver.sv
// Directed bench for b2s_receiver: table of frames plus abort, reset and glitch sequences.
module tb_b2s_receiver;

`ifdef B2S_RX_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        b2s_din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        frame_err;
  logic [5:0]  bit_cnt;

  b2s_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .b2s_din    (b2s_din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  logic [5:0] bc_at_valid = '0;
  logic lat_pre, lat_at;

  always @(negedge clk) begin
    if (dout_valid) begin
      valid_cnt++;
      bc_at_valid = bit_cnt;
    end
    if (frame_err) err_cnt++;
    if (dout_valid && frame_err) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    b2s_din = v;
    repeat (n) @(negedge clk);
  endtask

  // Transmitter timing: 1 = low w1 / high 149, 0 = low w0 / high 31.
  task automatic send_frame(input int start_low, input logic [31:0] data, input int w1,
                            input int w0, input bit glitch, input int nbits);
    drive(1'b1, 20);
    drive(1'b0, start_low);
    drive(1'b1, 20);
    for (int i = 0; i < nbits; i++) begin
      if (data[i])
        drive(1'b0, w1);
      else if (glitch) begin
        drive(1'b0, 60);
        drive(1'b1, 1);
        drive(1'b0, 75);
      end else
        drive(1'b0, w0);
      if (i == 31) begin
        b2s_din = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        lat_pre = dout_valid;
        @(negedge clk);
        lat_at = dout_valid;
        drive(1'b1, 200);
      end else
        drive(1'b1, data[i] ? 149 : 31);
    end
  endtask

  typedef struct {
    int          start_low;
    logic [31:0] data;
    int          w1;
    int          w0;
    bit          exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, e0;

    vecs[0] = '{20, 32'hA5C3_0F96, 18, 136, 1'b1, 32'hA5C3_0F96};
    vecs[1] = '{20, 32'h0000_0081, 76, 136, 1'b1, 32'h0000_0081};
    vecs[2] = '{20, 32'h0000_0081, 77, 136, 1'b1, 32'h0000_0000};
    vecs[3] = '{12, 32'h3C3C_5AA5, 18, 136, 1'b1, 32'h3C3C_5AA5};
    vecs[4] = '{28, 32'h0000_FFFF, 18, 136, 1'b1, 32'h0000_FFFF};
    vecs[5] = '{11, 32'h0000_0000, 18, 136, 1'b0, 32'h0000_FFFF};
    vecs[6] = '{29, 32'h0000_0000, 18, 136, 1'b0, 32'h0000_FFFF};
    vecs[7] = '{20, 32'h8000_0001, 18, 136, 1'b1, 32'h8000_0001};

    rst = 1'b1;
    b2s_din = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dout", dout, 32'h0);
    check("reset_flags", {29'h0, dout_valid, frame_err, busy}, 32'h0);
    check("reset_bit_cnt", 32'(bit_cnt), 32'h0);
    rst = 1'b0;
    drive(1'b1, 30);

    for (int k = 0; k < 8; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      if (vecs[k].exp_valid) begin
        send_frame(vecs[k].start_low, vecs[k].data, vecs[k].w1, vecs[k].w0, 1'b0, 32);
        check($sformatf("vec%0d_latency_pre", k), 32'(lat_pre), 32'h0);
        check($sformatf("vec%0d_latency_at", k), 32'(lat_at), 32'h1);
        check($sformatf("vec%0d_bit_cnt_at_valid", k), 32'(bc_at_valid), 32'd32);
      end else begin
        drive(1'b1, 20);
        drive(1'b0, vecs[k].start_low);
        drive(1'b1, 300);
      end
      check($sformatf("vec%0d_dout", k), dout, vecs[k].exp_dout);
      check($sformatf("vec%0d_valid_pulses", k), valid_cnt - v0, vecs[k].exp_valid ? 1 : 0);
      check($sformatf("vec%0d_err_pulses", k), err_cnt - e0, vecs[k].exp_valid ? 0 : 1);
      check($sformatf("vec%0d_busy_idle", k), 32'(busy), 32'h0);
      check($sformatf("vec%0d_bit_cnt_idle", k), 32'(bit_cnt), 32'h0);
    end

    // Abort during bit 10 with a 1280-clk low, then a clean frame
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(20, 32'h0000_02AA, 18, 136, 1'b0, 10);
    check("abort_busy_before", 32'(busy), 32'h1);
    check("abort_bit_cnt_before", 32'(bit_cnt), 32'd10);
    b2s_din = 1'b0;
    repeat (395) @(negedge clk);
    check("abort_no_err_early", err_cnt - e0, 0);
    repeat (25) @(negedge clk);
    check("abort_err", err_cnt - e0, 1);
    check("abort_busy_cleared", 32'(busy), 32'h0);
    repeat (1280 - 420) @(negedge clk);
    drive(1'b1, 200);
    check("abort_dout_held", dout, 32'h8000_0001);
    check("abort_no_valid", valid_cnt - v0, 0);
    send_frame(20, 32'h0000_0001, 18, 136, 1'b0, 32);
    check("after_abort_dout", dout, 32'h0000_0001);
    check("after_abort_valid", valid_cnt - v0, 1);
    check("after_abort_err", err_cnt - e0, 1);

    // Reset after 5 bits, mid-way through the low of bit 5
    e0 = err_cnt;
    send_frame(20, 32'hFFFF_FFFF, 18, 136, 1'b0, 5);
    drive(1'b0, 10);
    check("rst_busy_before", 32'(busy), 32'h1);
    check("rst_bit_cnt_before", 32'(bit_cnt), 32'd5);
    rst = 1'b1;
    b2s_din = 1'b1;
    @(negedge clk);
    check("rst_dout_cleared", dout, 32'h0);
    check("rst_state_cleared", {26'h0, bit_cnt}, 32'h0);
    check("rst_flags_cleared", {29'h0, busy, frame_err, dout_valid}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 40);
    v0 = valid_cnt;
    send_frame(20, 32'hFFFF_FFFF, 18, 136, 1'b0, 32);
    check("after_rst_dout", dout, 32'hFFFF_FFFF);
    check("after_rst_valid", valid_cnt - v0, 1);
    check("after_rst_no_err", err_cnt - e0, 0);

    // 1-clk high glitches inside every 136-clk low
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(20, 32'h1234_5678, 18, 136, 1'b1, 32);
    drive(1'b1, 2500);
`ifdef B2S_RX_GLITCH_FILTER_EN
    check("glitch_filtered_dout", dout, 32'h1234_5678);
    check("glitch_filtered_valid", valid_cnt - v0, 1);
    check("glitch_filtered_err", err_cnt - e0, 0);
`else
    check("glitch_unfiltered_corrupt",
          32'(((err_cnt - e0) != 0) || (dout != 32'h1234_5678)), 32'h1);
`endif

    check("valid_err_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
